data_memory_responder: RTL and testbench

MEM-stage data memory responder: the consumer of the EX/MEM pipeline register's memory-request outputs. It accepts one load or store per request, applies a configurable number of wait states, performs the access on an internal word-addressed RAM, and returns load data toward the MEM/WB register. While an access is in flight it drives `stall` to the hazard unit so the upstream barriers hold.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_ram.sv | 38 +++
 rtl/data_memory_responder.sv | 159 +++++++++++++++
 tb/tb_data_memory_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the MEM-stage data memory responder.
// Optional feature macro used by the top level: MISALIGN_TRAP_EN.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   localparam int DMEM_DEPTH       = 256;
   localparam int DMEM_WAIT_CYCLES = 2;
   localparam int DMEM_CNT_W       = 4;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous write and registered read share one edge.
// The array itself is never reset; only the read register clears on reset so
// that the load-data output starts from a known value.
module dmem_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;

   // Array write port (no reset so it maps onto block RAM).
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Registered read; holds the last loaded word until the next read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= 32'd0;
      end else if (re) begin
         rdata_q <= mem[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// MEM-stage data memory responder: latches one load/store, waits WAIT_CYCLES
// extra cycles, performs the access on dmem_ram and returns load data.
// Optional feature macro: MISALIGN_TRAP_EN (reject accesses with addr[1:0]!=0).
module data_memory_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH       = DMEM_DEPTH,
   parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] memAluResult,
   input  logic [31:0] memMemoryWriteData,
   input  logic        memMemWrite,
   input  logic        memMemToReg,
   output logic [31:0] memReadData,
   output logic        memReadValid,
   output logic        stall
`ifdef MISALIGN_TRAP_EN
   ,
   output logic        misaligned
`endif
);

   localparam int AW = $clog2(DEPTH);

   dmem_state_t           state_q, state_d;
   logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  store_q, store_d;
   logic                  load_q, load_d;
   logic                  valid_q, valid_d;
`ifdef MISALIGN_TRAP_EN
   logic                  mis_q, mis_d;
`endif

   logic pending;
   logic misalign_req;
   logic ram_we;
   logic ram_re;

   assign pending = memMemWrite | memMemToReg;

`ifdef MISALIGN_TRAP_EN
   assign misalign_req = (memAluResult[1:0] != 2'b00);
`else
   assign misalign_req = 1'b0;
`endif

   // Address bits outside the word index are deliberately ignored (wrap).
   logic addr_unused;
   assign addr_unused = &{1'b0, memAluResult[31:AW+2], memAluResult[1:0]};

   // Next-state, counter and request-latch logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      store_d = store_q;
      load_d  = load_q;
      valid_d = 1'b0;
      ram_we  = 1'b0;
      ram_re  = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (pending) begin
               if (misalign_req) begin
                  // Rejected access: skip BUSY, never touch the RAM.
                  state_d = DONE;
`ifdef MISALIGN_TRAP_EN
                  mis_d   = 1'b1;
`endif
               end else begin
                  addr_d  = memAluResult[AW+1:2];
                  wdata_d = memMemoryWriteData;
                  store_d = memMemWrite;
                  // Store wins when both request lines are high.
                  load_d  = memMemToReg & ~memMemWrite;
                  cnt_d   = DMEM_CNT_W'(WAIT_CYCLES);
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - DMEM_CNT_W'(1);
            end else begin
               ram_we  = store_q;
               ram_re  = load_q;
               valid_d = load_q;
               state_d = DONE;
            end
         end
         DONE: begin
            // Inputs still show the finished request here, so ignore them.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with asynchronous reset; reset aborts any access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         store_q <= 1'b0;
         load_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         store_q <= store_d;
         load_q  <= load_d;
         valid_q <= valid_d;
      end
   end

`ifdef MISALIGN_TRAP_EN
   // One-cycle registered pulse for a rejected access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= mis_d;
      end
   end

   assign misaligned = mis_q;
`endif

   dmem_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (memReadData)
   );

   assign memReadValid = valid_q;
   assign stall = ~reset & (((state_q == IDLE) & pending) | (state_q == BUSY));

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder (DEPTH=256, WAIT_CYCLES=2).
// Build with MISALIGN_TRAP_EN defined to exercise the misaligned trap.
module tb_data_memory_responder;

   localparam int DEPTH = 256;
   localparam int WAIT  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] memAluResult;
   logic [31:0] memMemoryWriteData;
   logic        memMemWrite;
   logic        memMemToReg;
   logic [31:0] memReadData;
   logic        memReadValid;
   logic        stall;
`ifdef MISALIGN_TRAP_EN
   logic        misaligned;
`endif

   data_memory_responder #(
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (WAIT)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .memAluResult       (memAluResult),
      .memMemoryWriteData (memMemoryWriteData),
      .memMemWrite        (memMemWrite),
      .memMemToReg        (memMemToReg),
      .memReadData        (memReadData),
      .memReadValid       (memReadValid),
      .stall              (stall)
`ifdef MISALIGN_TRAP_EN
      ,
      .misaligned         (misaligned)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_model [DEPTH];
   logic [31:0] model_rd = 32'd0;
   int          cyc = 0;
   int          mis_cyc = -1;
   int          n_checks = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops the expected load result whenever the DUT presents one.
   always @(negedge clk) begin
      if (!reset) begin
         if (memReadValid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("load_data", memReadData, e.data);
               check("load_cycle", cyc, e.cyc);
               model_rd = e.data;
               $display("load done: data=%h cycle=%0d", memReadData, cyc);
            end
         end
         check("hold_data", memReadData, model_rd);
`ifdef MISALIGN_TRAP_EN
         check("misaligned", {31'd0, misaligned}, {31'd0, cyc == mis_cyc});
`endif
      end
   end

   // Issue one request (called just after a rising edge) and follow it to DONE.
   task automatic access(input logic [31:0] addr, input logic [31:0] data,
                         input logic we, input logic re);
      int  c0;
      int  idx;
      int  nstall;
      int  exp_stall;
      bit  trap;
      bit  done;
      c0   = cyc;
      idx  = (addr / 4) % DEPTH;
      trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap = (addr % 4) != 0;
`endif
      memAluResult       = addr;
      memMemoryWriteData = data;
      memMemWrite        = we;
      memMemToReg        = re;
      if (trap) begin
         mis_cyc   = c0 + 1;
         exp_stall = 1;
      end else begin
         exp_stall = WAIT + 2;
         if (we) mem_model[idx] = data;
         else if (re) exp_q.push_back('{mem_model[idx], c0 + WAIT + 2});
      end
      $display("req: addr=%h data=%h we=%0b re=%0b trap=%0b cycle=%0d", addr, data, we, re, trap, c0);
      nstall = 0;
      done   = 1'b0;
      for (int n = 0; n < 40 && !done; n++) begin
         @(negedge clk);
         if (stall) nstall++;
         else done = 1'b1;
      end
      if (!done) check("stall_timeout", 32'd1, 32'd0);
      check("stall_cycles", nstall, exp_stall);
      @(posedge clk);
      #1;
      memMemWrite = 1'b0;
      memMemToReg = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      int          i;
      int          op;
      reset              = 1'b1;
      memAluResult       = 32'd0;
      memMemoryWriteData = 32'd0;
      memMemWrite        = 1'b1;
      memMemToReg        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_stall", {31'd0, stall}, 32'd0);
      check("reset_valid", {31'd0, memReadValid}, 32'd0);
      check("reset_rdata", memReadData, 32'd0);
`ifdef MISALIGN_TRAP_EN
      check("reset_mis", {31'd0, misaligned}, 32'd0);
`endif
      memMemWrite = 1'b0;
      reset       = 1'b0;
      @(posedge clk);
      #1;

      // Store then load.
      access(32'h10, 32'hDEADBEEF, 1'b1, 1'b0);
      access(32'h10, 32'h0, 1'b0, 1'b1);
      // Wrap-around: 0x400 aliases word 0.
      access(32'h400, 32'h12345678, 1'b1, 1'b0);
      access(32'h000, 32'h0, 1'b0, 1'b1);
      // Simultaneous request: store wins, no load data.
      access(32'h20, 32'hA5A5A5A5, 1'b1, 1'b1);
      access(32'h20, 32'h0, 1'b0, 1'b1);

      // Reset in the middle of a store must abort it.
      access(32'h30, 32'h22222222, 1'b1, 1'b0);
      memAluResult       = 32'h30;
      memMemoryWriteData = 32'h11111111;
      memMemWrite        = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset    = 1'b1;
      model_rd = 32'd0;
      exp_q.delete();
      #1;
      check("midrst_stall", {31'd0, stall}, 32'd0);
      check("midrst_valid", {31'd0, memReadValid}, 32'd0);
      check("midrst_rdata", memReadData, 32'd0);
      memMemWrite = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      access(32'h30, 32'h0, 1'b0, 1'b1);

`ifdef MISALIGN_TRAP_EN
      access(32'h13, 32'h0, 1'b0, 1'b1);
      access(32'h32, 32'h33333333, 1'b1, 1'b0);
      access(32'h30, 32'h0, 1'b0, 1'b1);
`endif

      // Randomized traffic on words 64..79 with random upper address bits.
      for (i = 0; i < 16; i++) begin
         a = ($urandom & 32'hFFFF_FC00) | ((64 + i) * 4);
         access(a, $urandom, 1'b1, 1'b0);
      end
      for (int k = 0; k < 60; k++) begin
         i  = $urandom_range(0, 15);
         op = $urandom_range(0, 3);
         a  = ($urandom & 32'hFFFF_FC00) | ((64 + i) * 4);
`ifdef MISALIGN_TRAP_EN
         if ($urandom_range(0, 7) == 0) a = a | $urandom_range(1, 3);
`endif
         case (op)
            0:       access(a, $urandom, 1'b1, 1'b0);
            1:       access(a, $urandom, 1'b1, 1'b1);
            default: access(a, 32'h0, 1'b0, 1'b1);
         endcase
      end

      repeat (5) @(posedge clk);
      #1;
      check("drain", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
